// File: rtl/muldiv_sequencer.sv
// Iterative mult/multu/div/divu unit owning the architectural HI/LO registers.
// Latency: busy for WIDTH+1 cycles after the accepting edge; new HI/LO visible WIDTH+2 cycles after start.
// Backpressure: stall = busy && (start || rd_hilo); no start is accepted while busy, EX re-presents it.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             rd_hilo,
    input  logic             hilo_sel,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             stall,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    typedef struct packed {
        logic isDiv;
        logic negRes;
        logic negRem;
    } opCtx_t;

    state_t             state;
    state_t             nextState;
    logic [CW-1:0]      counter;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    opCtx_t             ctx;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;

    logic               isSigned;
    logic               aNeg;
    logic               bNeg;
    logic               divZero;
    logic               launch;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;

    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH-1:0]   divDiff;
    logic               divFits;
    logic [2*WIDTH-1:0] stepNext;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix;
    logic [WIDTH-1:0]   remFix;

    always_comb begin
        isSigned = ~op[0];
        aNeg     = isSigned & src_a[WIDTH-1];
        bNeg     = isSigned & src_b[WIDTH-1];
        aMag     = aNeg ? -src_a : src_a;
        bMag     = bNeg ? -src_b : src_b;
        divZero  = start && (state == IDLE) && op[1] && (src_b == '0);
        launch   = start && (state == IDLE) && !divZero;
    end

    // acc holds {accumulator, multiplier} for mult and {remainder, quotient} for div.
    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divFits  = divShift >= {1'b0, operand};
        divDiff  = divShift[WIDTH-1:0] - operand;
        if (ctx.isDiv) begin
            stepNext = divFits ? {divDiff, acc[WIDTH-2:0], 1'b1}
                               : {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            stepNext = acc[0] ? {mulSum, acc[WIDTH-1:1]}
                              : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
        end
        prodFix = ctx.negRes ? -acc : acc;
        quoFix  = ctx.negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remFix  = ctx.negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (launch) nextState = RUN;
            RUN:     if (counter == CW'(1)) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        stall    = busy && (start || rd_hilo);
        hilo_out = hilo_sel ? hiReg : loReg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter     <= '0;
            acc         <= '0;
            operand     <= '0;
            ctx         <= '0;
            hiReg       <= '0;
            loReg       <= '0;
            div_by_zero <= 1'b0;
        end else begin
            div_by_zero <= divZero;
            case (state)
                IDLE: begin
                    if (launch) begin
                        counter    <= CW'(WIDTH);
                        ctx.isDiv  <= op[1];
                        ctx.negRes <= aNeg ^ bNeg;
                        ctx.negRem <= op[1] & aNeg;
                        if (op[1]) begin
                            acc     <= {{WIDTH{1'b0}}, aMag};
                            operand <= bMag;
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, bMag};
                            operand <= aMag;
                        end
                    end
                end
                RUN: begin
                    acc     <= stepNext;
                    counter <= counter - CW'(1);
                end
                FIX: begin
                    // HI/LO change only here, in one shot.
                    if (ctx.isDiv) begin
                        loReg <= quoFix;
                        hiReg <= remFix;
                    end else begin
                        hiReg <= prodFix[2*WIDTH-1:WIDTH];
                        loReg <= prodFix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed plan cases plus randomized ops against an arithmetic model.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [W-1:0]  src_a = '0;
    logic [W-1:0]  src_b = '0;
    logic          rd_hilo = 1'b0;
    logic          hilo_sel = 1'b0;
    logic [W-1:0]  hilo_out;
    logic          busy;
    logic          stall;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] mHi = '0;
    logic [W-1:0] mLo = '0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .rd_hilo(rd_hilo), .hilo_sel(hilo_sel),
        .hilo_out(hilo_out), .busy(busy), .stall(stall), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one op; HI/LO untouched on a zero divisor.
    task automatic ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          inout logic [W-1:0] hi, inout logic [W-1:0] lo, output logic dbz);
        int sa, sb;
        longint la, lb;
        logic [63:0] p;
        dbz = 1'b0;
        sa = a;
        sb = b;
        la = sa;
        lb = sb;
        case (o)
            2'd0: begin p = la * lb; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            2'd2: begin
                if (b == 0) dbz = 1'b1;
                else begin lo = 32'(la / lb); hi = 32'(la % lb); end
            end
            default: begin
                if (b == 0) dbz = 1'b1;
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eHi, eLo;
        logic eDbz;
        int n;
        eHi = mHi;
        eLo = mLo;
        ref_op(o, a, b, eHi, eLo, eDbz);
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL accept_idle: stall=%b busy=%b, required 0/0", stall, busy);
        end
        tick();
        start = 1'b0;
        #1;
        checks++;
        if (div_by_zero !== eDbz) begin
            errors++;
            $display("FAIL dbz_pulse: got %b, required %b (op=%0d b=%h)", div_by_zero, eDbz, o, b);
        end
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            hilo_sel = 1'($urandom);
            #1;
            checks++;
            if (hilo_out !== (hilo_sel ? mHi : mLo)) begin
                errors++;
                $display("FAIL hilo_hold: got %h, required %h (sel=%b)", hilo_out, hilo_sel ? mHi : mLo, hilo_sel);
            end
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL stall_idle_pipe: got %b, required 0", stall);
            end
            tick();
        end
        checks++;
        if (n != (eDbz ? 0 : W + 1)) begin
            errors++;
            $display("FAIL busy_cycles: got %0d, required %0d (op=%0d a=%h b=%h)", n, eDbz ? 0 : W + 1, o, a, b);
        end
        tick();
        checks++;
        if (div_by_zero !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_op_idle: dbz=%b busy=%b, required 0/0", div_by_zero, busy);
        end
        hilo_sel = 1'b0;
        #1;
        checks++;
        if (hilo_out !== eLo) begin
            errors++;
            $display("FAIL lo_result: got %h, required %h (op=%0d a=%h b=%h)", hilo_out, eLo, o, a, b);
        end
        hilo_sel = 1'b1;
        #1;
        checks++;
        if (hilo_out !== eHi) begin
            errors++;
            $display("FAIL hi_result: got %h, required %h (op=%0d a=%h b=%h)", hilo_out, eHi, o, a, b);
        end
        mHi = eHi;
        mLo = eLo;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b stall=%b dbz=%b, required 0", busy, stall, div_by_zero);
        end
        for (int s = 0; s < 2; s++) begin
            hilo_sel = 1'(s);
            #1;
            checks++;
            if (hilo_out !== '0) begin
                errors++;
                $display("FAIL reset_hilo: sel=%0d got %h, required 0", s, hilo_out);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [1:0]   dOp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [W-1:0] dA  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'h80000000};
        logic [W-1:0] dB  [5] = '{32'd3, 32'hFFFFFFFF, 32'd2, 32'd7, 32'hFFFFFFFF};
        logic [W-1:0] dHi [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd2, 32'd0};
        logic [W-1:0] dLo [5] = '{32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFFD, 32'd14, 32'h80000000};
        for (int i = 0; i < 5; i++) begin
            do_op(dOp[i], dA[i], dB[i]);
            hilo_sel = 1'b1;
            #1;
            checks++;
            if (hilo_out !== dHi[i]) begin
                errors++;
                $display("FAIL directed_hi[%0d]: got %h, required %h", i, hilo_out, dHi[i]);
            end
            hilo_sel = 1'b0;
            #1;
            checks++;
            if (hilo_out !== dLo[i]) begin
                errors++;
                $display("FAIL directed_lo[%0d]: got %h, required %h", i, hilo_out, dLo[i]);
            end
            tick();
        end
    endtask

    task automatic test_div_by_zero();
        do_op(2'd3, 32'h451, 32'h20);
        do_op(2'd3, 32'd5, 32'd0);
        hilo_sel = 1'b1;
        #1;
        checks++;
        if (hilo_out !== 32'h11) begin
            errors++;
            $display("FAIL dbz_keep_hi: got %h, required 00000011", hilo_out);
        end
        hilo_sel = 1'b0;
        #1;
        checks++;
        if (hilo_out !== 32'h22) begin
            errors++;
            $display("FAIL dbz_keep_lo: got %h, required 00000022", hilo_out);
        end
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] special [6] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd2};
        logic [W-1:0] v [2];
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 2))
                    0:       v[k] = $urandom;
                    1:       v[k] = $urandom_range(0, 40);
                    default: v[k] = special[$urandom_range(0, 5)];
                endcase
            end
            do_op(2'($urandom_range(0, 3)), v[0], v[1]);
            tick();
        end
    endtask

    task automatic test_stall_rd();
        logic [W-1:0] eHi, eLo;
        logic eDbz;
        eHi = mHi;
        eLo = mLo;
        ref_op(2'd0, 32'hFFFF1234, 32'h00C0FFEE, eHi, eLo, eDbz);
        start = 1'b1; op = 2'd0; src_a = 32'hFFFF1234; src_b = 32'h00C0FFEE;
        #1;
        tick();
        start = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_cycle1: stall=%b busy=%b, required 0/1", stall, busy);
        end
        tick();
        rd_hilo = 1'b1;
        for (int c = 2; c <= W + 1; c++) begin
            hilo_sel = 1'($urandom);
            #1;
            checks++;
            if (stall !== 1'b1) begin
                errors++;
                $display("FAIL rd_stall cycle %0d: got %b, required 1", c, stall);
            end
            tick();
        end
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_release: stall=%b busy=%b, required 0/0", stall, busy);
        end
        hilo_sel = 1'b0;
        #1;
        checks++;
        if (hilo_out !== eLo) begin
            errors++;
            $display("FAIL rd_new_lo: got %h, required %h", hilo_out, eLo);
        end
        hilo_sel = 1'b1;
        #1;
        checks++;
        if (hilo_out !== eHi) begin
            errors++;
            $display("FAIL rd_new_hi: got %h, required %h", hilo_out, eHi);
        end
        rd_hilo = 1'b0;
        mHi = eHi;
        mLo = eLo;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] h1, l1, h2, l2;
        logic d;
        int n;
        h1 = mHi; l1 = mLo;
        ref_op(2'd0, 32'hFFFFFF9C, 32'd12345, h1, l1, d);
        h2 = h1; l2 = l1;
        ref_op(2'd3, 32'hDEADBEEF, 32'd977, h2, l2, d);
        start = 1'b1; op = 2'd0; src_a = 32'hFFFFFF9C; src_b = 32'd12345;
        #1;
        tick();
        op = 2'd3; src_a = 32'hDEADBEEF; src_b = 32'd977;
        for (int c = 1; c <= W + 1; c++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_hold cycle %0d: stall=%b busy=%b, required 1/1", c, stall, busy);
            end
            tick();
        end
        hilo_sel = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || hilo_out !== l1) begin
            errors++;
            $display("FAIL b2b_first: stall=%b lo=%h, required 0/%h", stall, hilo_out, l1);
        end
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        checks++;
        if (n != W + 1) begin
            errors++;
            $display("FAIL b2b_second_busy: got %0d, required %0d", n, W + 1);
        end
        hilo_sel = 1'b0;
        #1;
        checks++;
        if (hilo_out !== l2) begin
            errors++;
            $display("FAIL b2b_second_lo: got %h, required %h", hilo_out, l2);
        end
        hilo_sel = 1'b1;
        #1;
        checks++;
        if (hilo_out !== h2) begin
            errors++;
            $display("FAIL b2b_second_hi: got %h, required %h", hilo_out, h2);
        end
        mHi = h2;
        mLo = l2;
        tick();
    endtask

    task automatic test_reset_mid();
        do_op(2'd1, 32'h12345678, 32'h9ABCDEF0);
        start = 1'b1; op = 2'd2; src_a = 32'hFFFFFC18; src_b = 32'd7;
        #1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rd_hilo = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_stall: got %b, required 1", stall);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: busy=%b stall=%b, required 0/0", busy, stall);
        end
        for (int s = 0; s < 2; s++) begin
            hilo_sel = 1'(s);
            #1;
            checks++;
            if (hilo_out !== '0) begin
                errors++;
                $display("FAIL mid_reset_hilo: sel=%0d got %h, required 0", s, hilo_out);
            end
        end
        tick();
        reset = 1'b0;
        rd_hilo = 1'b0;
        mHi = '0;
        mLo = '0;
        tick();
        do_op(2'd1, 32'd6, 32'd7);
        hilo_sel = 1'b0;
        #1;
        checks++;
        if (hilo_out !== 32'd42) begin
            errors++;
            $display("FAIL mid_after_lo: got %h, required 0000002a", hilo_out);
        end
        hilo_sel = 1'b1;
        #1;
        checks++;
        if (hilo_out !== 32'd0) begin
            errors++;
            $display("FAIL mid_after_hi: got %h, required 00000000", hilo_out);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_stall_rd();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS pipeline. It accepts mult/multu/div/divu from the EX stage and runs a shift-add multiply or restoring divide over WIDTH cycles. It raises a pipeline stall when a new muldiv op or an mfhi/mflo reaches EX while the unit is busy. The hazard logic ORs its stall output into the IF/ID/EX hold enables.

Parameters:
WIDTH  32  operand width; HI and LO are each WIDTH bits

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
start  in  1  EX holds a mult/multu/div/divu this cycle
op  in  2  00 mult, 01 multu, 10 div, 11 divu
src_a  in  WIDTH  rs operand (multiplicand / dividend)
src_b  in  WIDTH  rt operand (multiplier / divisor)
rd_hilo  in  1  EX holds mfhi/mflo this cycle
hilo_sel  in  1  0 = LO, 1 = HI
hilo_out  out  WIDTH  selected HI/LO register, combinational mux
busy  out  1  operation in flight
stall  out  1  pipeline hold request
div_by_zero  out  1  one-cycle pulse on a div/divu with src_b == 0

Behaviour:
- Reset: state IDLE; HI = LO = 0; busy = 0; stall = 0; div_by_zero = 0; counter = 0. Reset during RUN or FIX aborts the operation and discards partial results.
- FSM states: IDLE, RUN, FIX.
- IDLE -> RUN: on start && !busy. The start edge latches:
  - operand magnitudes (|x| for signed ops, raw value for unsigned);
  - result sign flags;
  - counter = WIDTH.
- IDLE -> IDLE on a div/divu with src_b == 0:
  - div_by_zero pulses on the next cycle;
  - HI/LO are unchanged;
  - busy is never asserted.
- RUN, one iteration per cycle, counter decrements each cycle:
  - Multiply: 2*WIDTH accumulator; add multiplicand if multiplier LSB = 1, then shift right.
  - Divide: restoring; shift remainder:quotient left, trial-subtract divisor, set quotient bit if non-negative.
- RUN -> FIX: when counter reaches 1 at the clock edge, i.e. after exactly WIDTH RUN cycles.
- FIX, one cycle, sign correction:
  - Signed mult: negate the 2*WIDTH product if the operand signs differ.
  - Signed div: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- FIX -> IDLE: at the end of FIX, write HI/LO:
  - mult: HI = product[2W-1:W], LO = product[W-1:0].
  - div: LO = quotient, HI = remainder.
- Latency: start accepted at cycle 0. busy is high on cycles 1..WIDTH+1. New HI/LO is visible on hilo_out from cycle WIDTH+2.
- stall = busy && (start || rd_hilo), combinational.
  - Any start or mfhi/mflo arriving while busy is held; the pipeline re-presents it.
  - No start is accepted while busy.
  - The upstream hold guarantees stable operands.
- HI/LO are never partially updated; hilo_out shows the old values throughout RUN/FIX.
- Signed overflow: div of 0x80000000 by 0xFFFFFFFF gives LO = 0x80000000, HI = 0, with no exception.
- The unit follows the MIPS convention of no interlock on a write-after-write to HI/LO other than via stall.

Test Plan:
- mult 0xFFFFFFFE (-2) x 3, WIDTH = 32 -> busy for 33 cycles; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA at cycle 34; stall = 0 throughout with no rd_hilo.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
- div -7 / 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1); divu 100 / 7 -> LO = 14, HI = 2.
- divu 5 / 0 with prior HI = 0x11, LO = 0x22 -> div_by_zero high exactly one cycle; busy stays 0; HI/LO remain 0x11/0x22.
- mult, then rd_hilo = 1 on cycle 2 -> stall = 1 cycles 2..33, stall = 0 on cycle 34 with hilo_out equal to the new value. Repeat with a back-to-back start instead of rd_hilo: the second op begins only after the first completes.
- reset asserted mid-RUN (cycle 10 of a div) -> busy, stall and HI/LO = 0 immediately (async); a subsequent multu 6 x 7 yields LO = 42, HI = 0.
